// File: rtl/dmem_mmio_bridge.sv
// Data-port bridge: decodes RAM / MMIO / unmapped accesses.
// MMIO block holds LEDs, a cycle counter and a console TX FIFO.
module dmem_mmio_bridge #(
  parameter int          RAM_BYTES  = 512,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        ram_we,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mmio_err
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_TOP  = 32'(RAM_BYTES);
  localparam logic [31:0] MMIO_TOP = MMIO_BASE + 32'd16;
  localparam logic [3:0]  DEPTH    = 4'(FIFO_DEPTH);

  localparam logic [1:0] OFF_LED  = 2'd0;
  localparam logic [1:0] OFF_CYC  = 2'd1;
  localparam logic [1:0] OFF_TX   = 2'd2;
  localparam logic [1:0] OFF_STAT = 2'd3;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_MMIO = 2'd2
  } sel_e;

  logic [31:0] r_cycle;
  logic [7:0]  r_leds;
  sel_e        r_sel;
  logic [31:0] r_mdata;
  logic [31:0] r_last;
  logic        r_pend;
  logic        r_err;
  logic [7:0]  r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [3:0]  r_cnt;
  logic        r_ovf;

  logic        w_ram;
  logic        w_mmio;
  logic        w_unm;
  logic        w_req;
  logic [1:0]  w_off;
  logic        w_wr_led;
  logic        w_push;
  logic        w_rd_stat;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic [31:0] w_mdata;
  logic [31:0] w_fresh;

  assign w_ram  = dAddress < RAM_TOP;
  assign w_mmio = (dAddress >= MMIO_BASE) &&
                  (dAddress < MMIO_TOP) &&
                  (dAddress[1:0] == 2'b00);
  assign w_unm  = !w_ram && !w_mmio;
  assign w_req  = MemRead | MemWrite;
  assign w_off  = dAddress[3:2] - MMIO_BASE[3:2];

  assign w_wr_led  = MemWrite & w_mmio & (w_off == OFF_LED);
  assign w_push    = MemWrite & w_mmio & (w_off == OFF_TX);
  assign w_rd_stat = MemRead & w_mmio & (w_off == OFF_STAT);

  assign ram_addr = dAddress[8:0];
  assign ram_din  = dWriteData;
  assign ram_we   = MemWrite & w_ram;

  assign w_empty  = (r_cnt == 4'd0);
  assign w_full   = (r_cnt == DEPTH);
  assign tx_valid = !w_empty;
  assign tx_data  = r_fifo[r_rp];
  assign w_pop    = tx_valid & tx_ready;
  assign w_accept = w_push & (~w_full | w_pop);

  assign leds     = r_leds;
  assign mmio_err = r_err;

  // MMIO read data as seen before this edge's updates
  always_comb begin
    w_mdata = 32'd0;
    unique case (w_off)
      OFF_LED:  w_mdata = {24'd0, r_leds};
      OFF_CYC:  w_mdata = r_cycle;
      OFF_TX:   w_mdata = 32'd0;
      OFF_STAT: w_mdata = {25'd0, r_cnt, r_ovf,
                           w_empty, w_full};
      default:  w_mdata = 32'd0;
    endcase
  end

  // Load data for the read captured on the previous edge
  always_comb begin
    w_fresh = 32'd0;
    unique case (r_sel)
      SEL_RAM:  w_fresh = ram_dout;
      SEL_MMIO: w_fresh = r_mdata;
      default:  w_fresh = 32'd0;
    endcase
  end

  assign dReadData = r_pend ? w_fresh : r_last;

  // Free-running cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cycle <= 32'd0;
    else      r_cycle <= r_cycle + 32'd1;
  end

  // LED register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_leds <= 8'd0;
    else if (w_wr_led) r_leds <= dWriteData[7:0];
  end

  // Capture region and MMIO data; latch last result for hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel   <= SEL_NONE;
      r_mdata <= 32'd0;
      r_pend  <= 1'b0;
      r_last  <= 32'd0;
    end else begin
      r_pend <= MemRead;
      if (r_pend) r_last <= w_fresh;
      if (MemRead) begin
        r_sel   <= w_ram  ? SEL_RAM :
                   w_mmio ? SEL_MMIO : SEL_NONE;
        r_mdata <= w_mdata;
      end
    end
  end

  // One-cycle error pulse on unmapped or misaligned access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= w_req & w_unm;
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_accept) r_fifo[r_wp] <= dWriteData[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= 4'd0;
    end else begin
      if (w_accept) r_wp <= r_wp + 1'b1;
      if (w_pop)    r_rp <= r_rp + 1'b1;
      unique case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky overflow; a new overflow beats a STATUS-read clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_ovf <= 1'b0;
    else if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
    else if (w_rd_stat)                r_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Scoreboard bench for dmem_mmio_bridge.
// Directed plan items followed by a randomized run.
module tb_dmem_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] dAddress = 32'd0;
  logic [31:0] dWriteData = 32'd0;
  logic [31:0] dReadData;
  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mmio_err;

  dmem_mmio_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .dAddress   (dAddress),
    .dWriteData (dWriteData),
    .dReadData  (dReadData),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .leds       (leds),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .mmio_err   (mmio_err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-first, cleared while reset is low
  logic [31:0] tb_ram [128];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) tb_ram[i] <= 32'd0;
      ram_dout <= 32'd0;
    end else begin
      if (ram_we) tb_ram[ram_addr[8:2]] <= ram_din;
      ram_dout <= tb_ram[ram_addr[8:2]];
    end
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  // Reference model state
  logic [31:0] m_cycle;
  logic [7:0]  m_leds;
  logic        m_ovf;
  logic        m_err;
  logic [7:0]  m_fifo [$];
  logic [31:0] ref_ram [128];
  logic        rst_drv = 1'b0;
  logic        rdy = 1'b0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_ram(logic [31:0] a);
    return a < 32'd512;
  endfunction

  function automatic logic is_mmio(logic [31:0] a);
    return a >= 32'h1000 && a < 32'h1010 && a[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] status();
    int n;
    n = m_fifo.size();
    return {25'd0, 4'(n), m_ovf, n == 0, n == 4};
  endfunction

  function automatic logic [31:0] exp_read(logic [31:0] a);
    if (is_ram(a)) return ref_ram[a[8:2]];
    if (is_mmio(a)) begin
      case (a - 32'h1000)
        32'd0:  return {24'd0, m_leds};
        32'd4:  return m_cycle;
        32'd12: return status();
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_cycle = 32'd0;
    m_leds  = 8'd0;
    m_ovf   = 1'b0;
    m_err   = 1'b0;
    m_fifo.delete();
    for (int i = 0; i < 128; i++) ref_ram[i] = 32'd0;
  endtask

  task automatic model_step(logic rd, logic wr,
                            logic [31:0] a, logic [31:0] d,
                            logic r);
    logic pop, full;
    m_cycle = m_cycle + 32'd1;
    m_err = (rd | wr) && !is_ram(a) && !is_mmio(a);
    if (wr && is_ram(a)) ref_ram[a[8:2]] = d;
    if (wr && a == 32'h1000) m_leds = d[7:0];
    pop  = r && m_fifo.size() != 0;
    full = m_fifo.size() == 4;
    if (rd && a == 32'h100C) m_ovf = 1'b0;
    if (pop) void'(m_fifo.pop_front());
    if (wr && a == 32'h1008) begin
      if (full && !pop) m_ovf = 1'b1;
      else m_fifo.push_back(d[7:0]);
    end
  endtask

  // One bus cycle: drive at negedge, step model at posedge
  task automatic cyc(logic rd, logic wr,
                     logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    rst = rst_drv;
    MemRead = rd;
    MemWrite = wr;
    dAddress = a;
    dWriteData = d;
    tx_ready = rdy;
    if (rd && rst) exp_q.push_back(exp_read(a));
    #1;
    check("ram_we", {31'd0, ram_we},
          {31'd0, wr && is_ram(a)});
    @(posedge clk);
    if (rst) model_step(rd, wr, a, d, rdy);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: pops expected load data, checks status outputs
  initial begin
    logic seen;
    logic [31:0] last_exp;
    logic [31:0] e;
    last_exp = 32'd0;
    forever begin
      @(posedge clk);
      seen = MemRead && rst;
      @(negedge clk);
      if (!rst) begin
        seen = 1'b0;
        last_exp = 32'd0;
      end
      if (seen) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rdata", dReadData, e);
          last_exp = e;
        end
      end else begin
        check("rdhold", dReadData, last_exp);
      end
      check("leds", {24'd0, leds}, {24'd0, m_leds});
      check("mmio_err", {31'd0, mmio_err}, {31'd0, m_err});
      check("tx_valid", {31'd0, tx_valid},
            {31'd0, m_fifo.size() != 0});
      if (m_fifo.size() != 0)
        check("tx_data", {24'd0, tx_data}, {24'd0, m_fifo[0]});
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [31:0] a;
    logic rd, wr;
    model_reset();
    #1;
    check("rst_rdata", dReadData, 32'd0);
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_txv", {31'd0, tx_valid}, 32'd0);
    check("rst_err", {31'd0, mmio_err}, 32'd0);
    idle(4);
    rst_drv = 1'b1;
    idle(19);
    cyc(1'b1, 1'b0, 32'h1004, 32'd0);
    idle(9);
    cyc(1'b1, 1'b0, 32'h1004, 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
    cyc(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    idle(2);
    cyc(1'b0, 1'b1, 32'h1000, 32'hFFFF_FFA5);
    cyc(1'b1, 1'b0, 32'h1000, 32'd0);
    cyc(1'b1, 1'b1, 32'h1000, 32'h0000_005A);
    cyc(1'b1, 1'b0, 32'h1000, 32'd0);
    idle(1);
    #1;
    force dut.r_cycle = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycle;
    m_cycle = 32'hFFFF_FFFE;
    idle(3);
    cyc(1'b1, 1'b0, 32'h1004, 32'd0);
    idle(1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 32'h1008, 32'h41 + 32'(i));
    cyc(1'b1, 1'b0, 32'h100C, 32'd0);
    cyc(1'b1, 1'b0, 32'h100C, 32'd0);
    rdy = 1'b1;
    idle(6);
    rdy = 1'b0;
    cyc(1'b1, 1'b0, 32'h0000_1002, 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_8000, 32'hDEAD_BEEF);
    idle(2);
    cyc(1'b0, 1'b1, 32'h1000, 32'h77);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 32'h1008, 32'h60 + 32'(i));
    #2;
    rst_drv = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_txv", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_leds", {24'd0, leds}, 32'd0);
    check("mid_rst_rdata", dReadData, 32'd0);
    model_reset();
    idle(2);
    rst_drv = 1'b1;
    idle(2);
    for (int n = 0; n < 600; n++) begin
      rdy = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 511));
        1: a = 32'h1000 + 32'($urandom_range(0, 15));
        2: a = 32'h1000 + 32'($urandom_range(0, 3) * 4);
        default: a = $urandom;
      endcase
      cyc(rd, wr, a, $urandom);
    end
    idle(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
